// File: rtl/cordic_multimode_if.sv
// Sample/result bundle for cordic_multimode: valid-qualified input vector plus mode tag,
// and the matching valid-qualified result. There is no backpressure in either direction.
interface cordic_multimode_if #(
    parameter int BW = 16,
    parameter int AW = 32
);
    // Handshake: a sample is taken on every rising clk edge where in_valid=1 (no ready);
    // a result is presented on every cycle where out_valid=1 and must be taken then.
    logic                 in_valid;
    logic                 in_mode;
    logic signed [BW-1:0] xin;
    logic signed [BW-1:0] yin;
    logic [AW-1:0]        theta;
    logic                 out_valid;
    logic                 out_mode;
    logic signed [BW+1:0] xout;
    logic signed [BW+1:0] yout;
    logic [AW-1:0]        zout;

    modport master (
        output in_valid, in_mode, xin, yin, theta,
        input  out_valid, out_mode, xout, yout, zout
    );

    modport slave (
        input  in_valid, in_mode, xin, yin, theta,
        output out_valid, out_mode, xout, yout, zout
    );
endinterface

// File: rtl/cordic_multimode.sv
// Fully pipelined rotation/vectoring CORDIC with a per-sample mode tag.
// Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation output stage (one extra cycle).
module cordic_multimode #(
    parameter int BW  = 16,
    parameter int AW  = 32,
    parameter int STG = 16
) (
    input logic clk,
    input logic rst,
    cordic_multimode_if.slave io
);
    localparam int XW = BW + 2;
    localparam int SH = 32 - AW;

    // atan(2^-i) as a fraction of a full turn, scaled to 2^32
    localparam logic [31:0] ATAN32 [0:30] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001
    };

    function automatic logic [AW-1:0] atan_aw(input int i);
        logic [32:0] tmp;
        tmp = ({1'b0, ATAN32[i]} + ((33'd1 << SH) >> 1)) >> SH;
        return tmp[AW-1:0];
    endfunction

    logic signed [XW-1:0] xs [0:STG];
    logic signed [XW-1:0] ys [0:STG];
    logic [AW-1:0]        zs [0:STG];
    logic                 vs [0:STG];
    logic                 ms [0:STG];

    logic signed [XW-1:0] xe, ye, x0_n, y0_n;
    logic [AW-1:0]        z0_n;
    logic signed [XW-1:0] xn [0:STG-1];
    logic signed [XW-1:0] yn [0:STG-1];
    logic [AW-1:0]        zn [0:STG-1];

    // Stage 0 folds the vector into the right half-plane so the micro-rotations converge
    always_comb begin
        xe   = {{2{io.xin[BW-1]}}, io.xin};
        ye   = {{2{io.yin[BW-1]}}, io.yin};
        x0_n = xe;
        y0_n = ye;
        z0_n = io.theta;
        if (io.in_mode) begin
            z0_n = '0;
            if (xe[XW-1]) begin
                if (!ye[XW-1]) begin
                    x0_n = ye;
                    y0_n = -xe;
                    z0_n = {2'b01, {(AW-2){1'b0}}};
                end else begin
                    x0_n = -ye;
                    y0_n = xe;
                    z0_n = {2'b11, {(AW-2){1'b0}}};
                end
            end
        end else begin
            case (io.theta[AW-1:AW-2])
                2'b01: begin
                    x0_n = -ye;
                    y0_n = xe;
                    z0_n = {2'b00, io.theta[AW-3:0]};
                end
                2'b10: begin
                    x0_n = ye;
                    y0_n = -xe;
                    z0_n = {2'b11, io.theta[AW-3:0]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < STG; i++) begin
            if (ms[i] ? ~ys[i][XW-1] : zs[i][AW-1]) begin
                xn[i] = xs[i] + (ys[i] >>> i);
                yn[i] = ys[i] - (xs[i] >>> i);
                zn[i] = zs[i] + atan_aw(i);
            end else begin
                xn[i] = xs[i] - (ys[i] >>> i);
                yn[i] = ys[i] + (xs[i] >>> i);
                zn[i] = zs[i] - atan_aw(i);
            end
        end
    end

    // Data registers only load behind a valid, so idle cycles hold the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= STG; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
                vs[i] <= 1'b0;
                ms[i] <= 1'b0;
            end
        end else begin
            vs[0] <= io.in_valid;
            if (io.in_valid) begin
                xs[0] <= x0_n;
                ys[0] <= y0_n;
                zs[0] <= z0_n;
                ms[0] <= io.in_mode;
            end
            for (int i = 0; i < STG; i++) begin
                vs[i+1] <= vs[i];
                if (vs[i]) begin
                    xs[i+1] <= xn[i];
                    ys[i+1] <= yn[i];
                    zs[i+1] <= zn[i];
                    ms[i+1] <= ms[i];
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [17:0] KINV = 18'sd39797;

    logic signed [XW+17:0] px, py;
    logic signed [XW-1:0]  gx, gy;
    logic [AW-1:0]         gz;
    logic                  gv, gm;

    assign px = (XW+18)'(xs[STG]) * (XW+18)'(KINV);
    assign py = (XW+18)'(ys[STG]) * (XW+18)'(KINV);

    // Taking bits above 16 of the product is an arithmetic shift, i.e. floor
    always_ff @(posedge clk) begin
        if (rst) begin
            gx <= '0;
            gy <= '0;
            gz <= '0;
            gv <= 1'b0;
            gm <= 1'b0;
        end else begin
            gv <= vs[STG];
            if (vs[STG]) begin
                gx <= px[XW+15:16];
                gy <= py[XW+15:16];
                gz <= zs[STG];
                gm <= ms[STG];
            end
        end
    end

    assign io.out_valid = gv;
    assign io.out_mode  = gm;
    assign io.xout      = gx;
    assign io.yout      = gy;
    assign io.zout      = gz;
`else
    assign io.out_valid = vs[STG];
    assign io.out_mode  = ms[STG];
    assign io.xout      = xs[STG];
    assign io.yout      = ys[STG];
    assign io.zout      = zs[STG];
`endif
endmodule

// File: tb/tb_cordic_multimode.sv
// Directed bench for cordic_multimode: reset state, rotation, quadrant folds, vectoring,
// a mixed-mode stream and a reset in the middle of a stream.
module tb_cordic_multimode;
    localparam int BW  = 16;
    localparam int AW  = 32;
    localparam int STG = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = STG + 2;
    localparam int A0  = 10000;
    localparam int A45 = 7071;
    localparam int AV  = 14142;
`else
    localparam int LAT = STG + 1;
    localparam int A0  = 16468;
    localparam int A45 = 11645;
    localparam int AV  = 23289;
`endif
    localparam int ZTOL = 1 << 18;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc;
    int   k;

    always #5 clk = ~clk;

    cordic_multimode_if #(.BW(BW), .AW(AW)) bus ();

    cordic_multimode #(.BW(BW), .AW(AW), .STG(STG)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input int x, input int y,
                         input logic [31:0] th);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.xin      = x[BW-1:0];
        bus.yin      = y[BW-1:0];
        bus.theta    = th;
    endtask

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_ang(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        int d;
        d = int'(obs - exp);
        total++;
        assert ((d <= ZTOL) && (d >= -ZTOL)) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the accepting edge (cycle 1) until out_valid is seen
    task automatic wait_out(input string tag, inout int c);
        while (bus.out_valid !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
        chk_eq(tag, c, LAT);
    endtask

    task automatic run_one(input string tag, input logic m, input int x, input int y,
                           input logic [31:0] th);
        int c;
        drive(1'b1, m, x, y, th);
        tick();
        drive(1'b0, 1'b0, 0, 0, 32'h0);
        c = 1;
        wait_out(tag, c);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1234, -567, 32'h12345678);
        tick();
        tick();
        chk_eq("rst_valid", bus.out_valid, 0);
        chk_eq("rst_mode", bus.out_mode, 0);
        chk_eq("rst_x", bus.xout, 0);
        chk_eq("rst_y", bus.yout, 0);
        chk_eq("rst_z", bus.zout, 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 32'h0);
        tick();

        run_one("rot45_lat", 1'b0, 10000, 0, 32'h20000000);
        chk_tol("rot45_x", bus.xout, A45, 4);
        chk_tol("rot45_y", bus.yout, A45, 4);
        chk_ang("rot45_z", bus.zout, 32'h0);
        chk_eq("rot45_mode", bus.out_mode, 0);
        tick();
        chk_eq("rot45_pulse", bus.out_valid, 0);
        chk_tol("rot45_hold", bus.xout, A45, 4);

        run_one("rot0_lat", 1'b0, 10000, 0, 32'h00000000);
        chk_tol("rot0_x", bus.xout, A0, 4);
        chk_tol("rot0_y", bus.yout, 0, 4);

        run_one("rot90_lat", 1'b0, 10000, 0, 32'h40000000);
        chk_tol("rot90_x", bus.xout, 0, 4);
        chk_tol("rot90_y", bus.yout, A0, 4);

        run_one("rot180_lat", 1'b0, 10000, 0, 32'h80000000);
        chk_tol("rot180_x", bus.xout, -A0, 4);
        chk_tol("rot180_y", bus.yout, 0, 4);

        run_one("vec135_lat", 1'b1, -10000, 10000, 32'h0);
        chk_tol("vec135_x", bus.xout, AV, 6);
        chk_tol("vec135_y", bus.yout, 0, 4);
        chk_ang("vec135_z", bus.zout, 32'h60000000);
        chk_eq("vec135_mode", bus.out_mode, 1);

        run_one("vec225_lat", 1'b1, -10000, -10000, 32'h0);
        chk_tol("vec225_x", bus.xout, AV, 6);
        chk_tol("vec225_y", bus.yout, 0, 4);
        chk_ang("vec225_z", bus.zout, 32'hA0000000);
        chk_eq("vec225_mode", bus.out_mode, 1);
        tick();

        // 20 back-to-back samples, even = rotation 45 deg, odd = vectoring 135 deg
        for (int t = 0; t < 20 + LAT + 1; t++) begin
            if (t < 20) begin
                if (t % 2 == 1) drive(1'b1, 1'b1, -10000, 10000, 32'h20000000);
                else            drive(1'b1, 1'b0, 10000, 0, 32'h20000000);
            end else begin
                drive(1'b0, 1'b0, 0, 0, 32'h0);
            end
            tick();
            k = t - LAT + 1;
            if (k >= 0 && k < 20) begin
                chk_eq("strm_valid", bus.out_valid, 1);
                chk_eq("strm_mode", bus.out_mode, k % 2);
                if (k % 2 == 1) begin
                    chk_tol("strm_vx", bus.xout, AV, 6);
                    chk_tol("strm_vy", bus.yout, 0, 4);
                    chk_ang("strm_vz", bus.zout, 32'h60000000);
                end else begin
                    chk_tol("strm_rx", bus.xout, A45, 4);
                    chk_tol("strm_ry", bus.yout, A45, 4);
                    chk_ang("strm_rz", bus.zout, 32'h0);
                end
            end else if (t == LAT - 2 || k == 20) begin
                chk_eq("strm_idle", bus.out_valid, 0);
            end
        end

        // Samples 1-4 in flight, reset lands on sample 5
        for (int s = 1; s <= 4; s++) begin
            drive(1'b1, 1'b0, 10000, 0, 32'h20000000);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, -10000, 10000, 32'h0);
        tick();
        rst = 1'b0;
        chk_eq("mrst_valid", bus.out_valid, 0);
        chk_eq("mrst_mode", bus.out_mode, 0);
        chk_eq("mrst_x", bus.xout, 0);
        chk_eq("mrst_y", bus.yout, 0);
        chk_eq("mrst_z", bus.zout, 0);
        drive(1'b1, 1'b1, -10000, -10000, 32'h0);
        tick();
        drive(1'b1, 1'b0, 10000, 0, 32'h40000000);
        tick();
        drive(1'b1, 1'b1, -10000, 10000, 32'h0);
        tick();
        drive(1'b0, 1'b0, 0, 0, 32'h0);
        cyc = 3;
        wait_out("mrst_lat", cyc);
        chk_eq("s6_mode", bus.out_mode, 1);
        chk_tol("s6_x", bus.xout, AV, 6);
        chk_ang("s6_z", bus.zout, 32'hA0000000);
        tick();
        chk_eq("s7_valid", bus.out_valid, 1);
        chk_eq("s7_mode", bus.out_mode, 0);
        chk_tol("s7_x", bus.xout, 0, 4);
        chk_tol("s7_y", bus.yout, A0, 4);
        tick();
        chk_eq("s8_valid", bus.out_valid, 1);
        chk_eq("s8_mode", bus.out_mode, 1);
        chk_ang("s8_z", bus.zout, 32'h60000000);
        tick();
        chk_eq("s8_end", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
